// File: rtl/tetris_board.sv
// tetris_board: 10x20 playfield of 3-bit piece codes with display/collision read ports and a line-clear sweeper.
// Optional feature macro: TETRIS_BOARD_FLASH_EN (hold full rows visible for FLASH_CYCLES before compaction).
module tetris_board #(
  parameter int          NUM_X        = 10,
  parameter int          NUM_Y        = 20,
  parameter logic [23:0] FLASH_CYCLES = 24'd6000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_board,
  input  logic [7:0]       query_pos,
  output logic [2:0]       query_res,
  input  logic [7:0]       rd_pos,
  output logic [2:0]       rd_val,
  input  logic             wr_en,
  input  logic [7:0]       wr_pos,
  input  logic [2:0]       wr_val,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [NUM_Y-1:0] which_lines_cleared,
  output logic [4:0]       lines_cleared
);

  localparam int                CELLS     = NUM_X * NUM_Y;
  localparam int                PTR_W     = $clog2(NUM_Y + 1);
  localparam logic [7:0]        CELLS_LIM = 8'(CELLS);
  localparam logic [PTR_W-1:0]  LAST_ROW  = PTR_W'(NUM_Y - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
`ifdef TETRIS_BOARD_FLASH_EN
    FLASH,
`endif
    COMPACT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cells_q [CELLS];
  logic [2:0]         cells_d [CELLS];
  logic [NUM_Y-1:0]   mask_q, mask_d;
  logic [4:0]         lines_q, lines_d;
  logic [PTR_W-1:0]   srcPtr_q, srcPtr_d;
  logic [PTR_W-1:0]   dstPtr_q, dstPtr_d;
  logic [2:0]         queryRes_q, queryRes_d;
  logic [NUM_Y-1:0]   rowFull;
  logic [NUM_Y-1:0]   scanMask;
  logic [PTR_W-1:0]   srcSel;
  logic               srcValid;
  logic [2:0]         srcRow [NUM_X];

`ifdef TETRIS_BOARD_FLASH_EN
  logic [23:0]        flashCnt_q, flashCnt_d;
`else
  logic               unusedFlashCycles;
  assign unusedFlashCycles = ^FLASH_CYCLES;
`endif

  assign rd_val        = (rd_pos < CELLS_LIM) ? cells_q[rd_pos] : 3'd0;
  assign query_res     = queryRes_q;
  assign lines_cleared = lines_q;

  always_comb begin
    rowFull = '1;
    for (int y = 0; y < NUM_Y; y++) begin
      for (int x = 0; x < NUM_X; x++) begin
        if (cells_q[y*NUM_X + x] == 3'd0) rowFull[y] = 1'b0;
      end
    end
    scanMask = mask_q | (rowFull[srcPtr_q] ? (NUM_Y'(1) << srcPtr_q) : '0);
  end

  // Compaction skips full source rows combinationally so that exactly one
  // destination row is written per cycle; the source never trails the destination.
  always_comb begin
    srcSel   = PTR_W'(NUM_Y);
    srcValid = 1'b0;
    for (int r = NUM_Y - 1; r >= 0; r--) begin
      if ((PTR_W'(r) >= srcPtr_q) && !mask_q[r]) begin
        srcSel   = PTR_W'(r);
        srcValid = 1'b1;
      end
    end
    for (int x = 0; x < NUM_X; x++) srcRow[x] = 3'd0;
    for (int y = 0; y < NUM_Y; y++) begin
      if (PTR_W'(y) == srcSel) begin
        for (int x = 0; x < NUM_X; x++) srcRow[x] = cells_q[y*NUM_X + x];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sweep_start) state_d = SCAN;
      SCAN: begin
        if (srcPtr_q == LAST_ROW) begin
          if (scanMask == '0) state_d = DONE;
`ifdef TETRIS_BOARD_FLASH_EN
          else                state_d = FLASH;
`else
          else                state_d = COMPACT;
`endif
        end
      end
`ifdef TETRIS_BOARD_FLASH_EN
      FLASH:   if (flashCnt_q == FLASH_CYCLES - 24'd1) state_d = COMPACT;
`endif
      COMPACT: if (dstPtr_q == LAST_ROW) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_board) state_d = IDLE;
  end

  always_comb begin
    sweep_busy          = (state_q != IDLE);
    sweep_done          = (state_q == DONE);
    which_lines_cleared = '0;
`ifdef TETRIS_BOARD_FLASH_EN
    if (state_q == FLASH) which_lines_cleared = mask_q;
`endif
  end

  always_comb begin
    cells_d    = cells_q;
    mask_d     = mask_q;
    lines_d    = lines_q;
    srcPtr_d   = srcPtr_q;
    dstPtr_d   = dstPtr_q;
    queryRes_d = (query_pos < CELLS_LIM) ? cells_q[query_pos] : 3'd0;
`ifdef TETRIS_BOARD_FLASH_EN
    flashCnt_d = flashCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_en && (wr_pos < CELLS_LIM)) cells_d[wr_pos] = wr_val;
        if (sweep_start) begin
          srcPtr_d = '0;
          mask_d   = '0;
          lines_d  = '0;
        end
      end
      SCAN: begin
        mask_d   = scanMask;
        srcPtr_d = srcPtr_q + PTR_ONE;
        if (rowFull[srcPtr_q]) lines_d = lines_q + 5'd1;
        if (srcPtr_q == LAST_ROW) begin
          srcPtr_d = '0;
          dstPtr_d = '0;
`ifdef TETRIS_BOARD_FLASH_EN
          flashCnt_d = '0;
`endif
        end
      end
`ifdef TETRIS_BOARD_FLASH_EN
      FLASH: flashCnt_d = flashCnt_q + 24'd1;
`endif
      COMPACT: begin
        for (int y = 0; y < NUM_Y; y++) begin
          if (PTR_W'(y) == dstPtr_q) begin
            for (int x = 0; x < NUM_X; x++) cells_d[y*NUM_X + x] = srcValid ? srcRow[x] : 3'd0;
          end
        end
        dstPtr_d = dstPtr_q + PTR_ONE;
        if (srcValid) srcPtr_d = srcSel + PTR_ONE;
      end
      default: ;
    endcase
    if (clear_board) begin
      for (int i = 0; i < CELLS; i++) cells_d[i] = 3'd0;
      mask_d     = '0;
      lines_d    = '0;
      queryRes_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= 3'd0;
      mask_q     <= '0;
      lines_q    <= '0;
      srcPtr_q   <= '0;
      dstPtr_q   <= '0;
      queryRes_q <= 3'd0;
`ifdef TETRIS_BOARD_FLASH_EN
      flashCnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      mask_q     <= mask_d;
      lines_q    <= lines_d;
      srcPtr_q   <= srcPtr_d;
      dstPtr_q   <= dstPtr_d;
      queryRes_q <= queryRes_d;
`ifdef TETRIS_BOARD_FLASH_EN
      flashCnt_q <= flashCnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tetris_board.sv
// tb_tetris_board: directed stimulus against a row-level board model, compared every cycle, plus literal pins.
// Honours TETRIS_BOARD_FLASH_EN the same way the design does.
module tb_tetris_board;

  localparam int NX = 10;
  localparam int NY = 20;
  localparam int NC = NX * NY;
  localparam int FC = 4;
`ifdef TETRIS_BOARD_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_board = 1'b0;
  logic [7:0]    query_pos = 8'd0;
  logic [2:0]    query_res;
  logic [7:0]    rd_pos = 8'd0;
  logic [2:0]    rd_val;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_pos = 8'd0;
  logic [2:0]    wr_val = 3'd0;
  logic          sweep_start = 1'b0;
  logic          sweep_busy;
  logic          sweep_done;
  logic [NY-1:0] which_lines_cleared;
  logic [4:0]    lines_cleared;

  always #5 clk = ~clk;

  tetris_board #(.NUM_X(NX), .NUM_Y(NY), .FLASH_CYCLES(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .clear_board(clear_board),
    .query_pos(query_pos), .query_res(query_res),
    .rd_pos(rd_pos), .rd_val(rd_val),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_val(wr_val),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .which_lines_cleared(which_lines_cleared), .lines_cleared(lines_cleared)
  );

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  bit compareOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: board as plain ints, and a sweep plan computed up front.
  int            mBoard [NC];
  int            pBoard [NC];
  logic [NY-1:0] pMask = '0;
  int            pLines = 0;
  int            pLen = 0;
  int            pC0 = 0;
  int            k = 0;
  int            mLines = 0;
  int            mQuery = 0;
  bit            mQueryValid = 1'b1;

  function automatic bit boardValidAt(input int kk);
    return !((pMask != '0) && (kk >= pC0) && (kk < pLen));
  endfunction

  function automatic logic [NY-1:0] expWhich();
    if (FLASH_ON && (pMask != '0) && (k >= NY + 1) && (k <= NY + FC)) return pMask;
    return '0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NC; i++) mBoard[i] = 0;
    k = 0; mLines = 0; mQuery = 0; mQueryValid = 1'b1; pMask = '0;
  endtask

  task automatic planSweep();
    int dst;
    bit full;
    pMask = '0; pLines = 0; dst = 0;
    for (int y = 0; y < NY; y++) begin
      full = 1'b1;
      for (int x = 0; x < NX; x++) if (mBoard[y*NX + x] == 0) full = 1'b0;
      if (full) begin
        pMask[y] = 1'b1;
        pLines++;
      end else begin
        for (int x = 0; x < NX; x++) pBoard[dst*NX + x] = mBoard[y*NX + x];
        dst++;
      end
    end
    for (int y = dst; y < NY; y++) for (int x = 0; x < NX; x++) pBoard[y*NX + x] = 0;
    pC0  = NY + ((FLASH_ON && (pMask != '0)) ? FC : 0) + 1;
    pLen = (pMask != '0) ? pC0 + NY : NY + 1;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clear_board) modelReset();
      else begin
        mQuery      = (query_pos < NC) ? mBoard[query_pos] : 0;
        mQueryValid = boardValidAt(k);
        if (k == 0) begin
          if (wr_en && (wr_pos < NC)) mBoard[wr_pos] = int'(wr_val);
          if (sweep_start) begin
            planSweep();
            k = 1;
            mLines = pLines;
          end
        end else if (k == pLen) k = 0;
        else begin
          k++;
          if (k == pLen) mBoard = pBoard;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sweep_done) doneCount++;
      if (rst_n && compareOn) begin
        checkOutput("busy", 32'(sweep_busy), 32'(k != 0));
        checkOutput("done", 32'(sweep_done), 32'((k != 0) && (k == pLen)));
        checkOutput("which", 32'(which_lines_cleared), 32'(expWhich()));
        if ((k == 0) || (k > NY)) checkOutput("lines", 32'(lines_cleared), 32'(mLines));
        if (mQueryValid) checkOutput("query", 32'(query_res), 32'(mQuery));
        if (boardValidAt(k)) checkOutput("rd", 32'(rd_val), (rd_pos < NC) ? 32'(mBoard[rd_pos]) : 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic clr, input logic we, input int wpos, input int wval,
                               input logic start, input int qpos, input int rpos);
    clear_board = clr; wr_en = we; wr_pos = 8'(wpos); wr_val = 3'(wval);
    sweep_start = start; query_pos = 8'(qpos); rd_pos = 8'(rpos);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, int'(query_pos), int'(rd_pos));
  endtask

  task automatic writeCell(input int x, input int y, input int v);
    applyStimulus(1'b0, 1'b1, y*NX + x, v, 1'b0, 0, 0);
  endtask

  task automatic checkCell(input string name, input int x, input int y, input int exp);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, y*NX + x, y*NX + x);
    checkOutput({name, "_rd"}, 32'(rd_val), 32'(exp));
    checkOutput({name, "_q"}, 32'(query_res), 32'(exp));
  endtask

  int cnt;
  int flashSeen;
  int doneBefore;

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    compareOn = 1'b1;
    checkOutput("rstBusy", 32'(sweep_busy), 32'd0);
    checkOutput("rstLines", 32'(lines_cleared), 32'd0);
    checkOutput("rstWhich", 32'(which_lines_cleared), 32'd0);
    checkOutput("rstQuery", 32'(query_res), 32'd0);

    // Empty-board sweep: done lands in cycle NY+1.
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
    cnt = 1;
    while (!sweep_done && cnt < 200) begin idle(1); cnt++; end
    checkOutput("emptyDoneCycle", 32'(cnt), 32'd21);
    idle(2);
    checkOutput("emptyLines", 32'(lines_cleared), 32'd0);
    checkCell("emptyA", 0, 0, 0);
    checkCell("emptyB", 7, 5, 0);
    checkCell("emptyC", 9, 19, 0);

    // Write latency and out-of-range handling.
    applyStimulus(1'b0, 1'b1, 5, 3, 1'b0, 5, 5);
    checkOutput("wrRdNext", 32'(rd_val), 32'd3);
    idle(1);
    checkOutput("wrQueryLater", 32'(query_res), 32'd3);
    applyStimulus(1'b0, 1'b1, 200, 6, 1'b0, 200, 200);
    idle(1);
    checkOutput("oorRd", 32'(rd_val), 32'd0);
    checkOutput("oorQuery", 32'(query_res), 32'd0);

    // Two full rows; the last write coincides with sweep_start.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    for (int x = 0; x < NX; x++) writeCell(x, 0, 1);
    writeCell(3, 1, 4);
    writeCell(7, 3, 5);
    for (int x = 0; x < NX - 1; x++) writeCell(x, 2, 1);
    applyStimulus(1'b0, 1'b1, 2*NX + 9, 1, 1'b1, 0, 0);
    cnt = 1; flashSeen = 0;
    while (!sweep_done && cnt < 200) begin
      if (which_lines_cleared == 20'h00005) flashSeen++;
      idle(1);
      cnt++;
    end
    checkOutput("twoRowsFlash", 32'(flashSeen), FLASH_ON ? 32'd4 : 32'd0);
    checkOutput("twoRowsLen", 32'(cnt), FLASH_ON ? 32'd45 : 32'd41);
    idle(1);
    checkOutput("twoRowsLines", 32'(lines_cleared), 32'd2);
    checkCell("row0x3", 3, 0, 4);
    checkCell("row0x0", 0, 0, 0);
    checkCell("row1x7", 7, 1, 5);
    checkCell("row2x9", 9, 2, 0);
    checkCell("row3x7", 7, 3, 0);

    // Writes and a second start during SCAN are ignored.
    writeCell(0, 0, 2);
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 0, 7, 1'b1, 0, 0);
    idle(60);
    checkOutput("busyOneDone", 32'(doneCount - doneBefore), 32'd1);
    checkCell("busyCell0", 0, 0, 2);

    // clear_board mid-COMPACT aborts without sweep_done.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    for (int x = 0; x < NX; x++) writeCell(x, 0, 6);
    writeCell(4, 1, 3);
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
    idle(NY + (FLASH_ON ? FC : 0) + 3);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    checkOutput("abortBusy", 32'(sweep_busy), 32'd0);
    idle(30);
    checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd0);
    checkCell("abortRow0", 4, 0, 0);
    checkCell("abortRow1", 4, 1, 0);

    // Asynchronous reset while full rows are flashing.
    for (int x = 0; x < NX; x++) writeCell(x, 1, 2);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
    idle(NY + 1);
    checkOutput("preResetWhich", 32'(which_lines_cleared), FLASH_ON ? 32'h2 : 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncWhich", 32'(which_lines_cleared), 32'd0);
    checkOutput("asyncBusy", 32'(sweep_busy), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkCell("asyncRow1", 5, 1, 0);
    checkCell("asyncRow0", 0, 0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
